label_table: RTL and testbench

//  Label table storing the per-label entries {typ, base, count} written by the

---
 rtl/label_table.sv | 235 +++++++++++++++++++++++
 tb/tb_label_table.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/label_table.sv
// Label table: per-label {valid, typ, base, count} entries with a pipelined
// lookup that resolves label+offset to an absolute address and checks set/type/range.
// Latency: lookup result two edges after acceptance; one lookup per cycle.
// Backpressure: lookups and writes are ignored while the post-reset invalidate
// sweep runs (rd_ready=0, busy=1); no stalls once idle.
//
// Ports:
//   clk, reset_n            clock and synchronous active-low reset
//   lbt_*                   write port (label id, type, base, count, write enable)
//   rd_req/rd_lbid/rd_typ/rd_ofs   lookup request (rd_typ=0 matches any type)
//   rd_ready, busy          table accepting lookups / sweep in progress
//   rd_valid, rd_addr, rd_count, rd_err, rd_errcode   registered lookup result
module label_table #(
  parameter int ADDR_W = 12,
  parameter int TYP_W  = 6,
  parameter int BASE_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] lbt_lbidw,
  input  logic [TYP_W-1:0]  lbt_typw,
  input  logic [BASE_W-1:0] lbt_basew,
  input  logic [BASE_W-1:0] lbt_countw,
  input  logic              lbt_we,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_lbid,
  input  logic [TYP_W-1:0]  rd_typ,
  input  logic [BASE_W-1:0] rd_ofs,
  output logic              rd_ready,
  output logic              busy,
  output logic              rd_valid,
  output logic [BASE_W-1:0] rd_addr,
  output logic [BASE_W-1:0] rd_count,
  output logic              rd_err,
  output logic [1:0]        rd_errcode
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_UNSET = 2'b01;
  localparam logic [1:0] ERR_TYPE  = 2'b10;
  localparam logic [1:0] ERR_RANGE = 2'b11;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_e;

  // ---------------------------------------------------------------------------
  // Sweep FSM
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic              clr_en;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    clr_en  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_en  = 1'b1;
        sweep_d = sweep_q + ADDR_W'(1);
        if (sweep_q == {ADDR_W{1'b1}}) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_CLEAR;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  assign busy     = (state_q == ST_CLEAR);
  assign rd_ready = (state_q == ST_IDLE);

  // ---------------------------------------------------------------------------
  // Storage. Valid bits are separate so the sweep can clear them one per cycle
  // without touching the payload arrays.
  // ---------------------------------------------------------------------------
  logic              valid_q [DEPTH];
  logic [TYP_W-1:0]  typ_q   [DEPTH];
  logic [BASE_W-1:0] base_q  [DEPTH];
  logic [BASE_W-1:0] cnt_q   [DEPTH];

  logic wr_en;
  logic rd_acc;

  assign wr_en  = reset_n && (state_q == ST_IDLE) && lbt_we;
  assign rd_acc = reset_n && (state_q == ST_IDLE) && rd_req;

  always_ff @(posedge clk) begin
    if (reset_n && clr_en) begin
      valid_q[sweep_q] <= 1'b0;
    end else if (wr_en) begin
      valid_q[lbt_lbidw] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      typ_q[lbt_lbidw]  <= lbt_typw;
      base_q[lbt_lbidw] <= lbt_basew;
      cnt_q[lbt_lbidw]  <= lbt_countw;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: table read. A write landing on the same edge as the request is
  // forwarded so the lookup sees it; the arrays themselves read old data.
  // ---------------------------------------------------------------------------
  logic              fwd;
  logic              s1_vld_q,  s1_vld_d;
  logic              s1_set_q,  s1_set_d;
  logic [TYP_W-1:0]  s1_typ_q,  s1_typ_d;
  logic [BASE_W-1:0] s1_base_q, s1_base_d;
  logic [BASE_W-1:0] s1_cnt_q,  s1_cnt_d;
  logic [TYP_W-1:0]  s1_rtyp_q, s1_rtyp_d;
  logic [BASE_W-1:0] s1_ofs_q,  s1_ofs_d;

  assign fwd = wr_en && (lbt_lbidw == rd_lbid);

  always_comb begin
    s1_vld_d  = rd_acc;
    s1_set_d  = s1_set_q;
    s1_typ_d  = s1_typ_q;
    s1_base_d = s1_base_q;
    s1_cnt_d  = s1_cnt_q;
    s1_rtyp_d = s1_rtyp_q;
    s1_ofs_d  = s1_ofs_q;
    if (rd_acc) begin
      s1_rtyp_d = rd_typ;
      s1_ofs_d  = rd_ofs;
      if (fwd) begin
        s1_set_d  = 1'b1;
        s1_typ_d  = lbt_typw;
        s1_base_d = lbt_basew;
        s1_cnt_d  = lbt_countw;
      end else begin
        s1_set_d  = valid_q[rd_lbid];
        s1_typ_d  = typ_q[rd_lbid];
        s1_base_d = base_q[rd_lbid];
        s1_cnt_d  = cnt_q[rd_lbid];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_vld_q  <= 1'b0;
      s1_set_q  <= 1'b0;
      s1_typ_q  <= '0;
      s1_base_q <= '0;
      s1_cnt_q  <= '0;
      s1_rtyp_q <= '0;
      s1_ofs_q  <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_set_q  <= s1_set_d;
      s1_typ_q  <= s1_typ_d;
      s1_base_q <= s1_base_d;
      s1_cnt_q  <= s1_cnt_d;
      s1_rtyp_q <= s1_rtyp_d;
      s1_ofs_q  <= s1_ofs_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: checks and address add. Precedence unset > type > range; the
  // address is still reported for type/range errors, zeroed only when unset.
  // ---------------------------------------------------------------------------
  logic              out_vld_q,  out_vld_d;
  logic [BASE_W-1:0] out_addr_q, out_addr_d;
  logic [BASE_W-1:0] out_cnt_q,  out_cnt_d;
  logic [1:0]        out_code_q, out_code_d;

  always_comb begin
    out_vld_d  = s1_vld_q;
    out_addr_d = out_addr_q;
    out_cnt_d  = out_cnt_q;
    out_code_d = out_code_q;
    if (s1_vld_q) begin
      if (!s1_set_q) begin
        out_code_d = ERR_UNSET;
        out_addr_d = '0;
        out_cnt_d  = '0;
      end else begin
        out_addr_d = s1_base_q + s1_ofs_q;
        out_cnt_d  = s1_cnt_q;
        if ((s1_rtyp_q != '0) && (s1_rtyp_q != s1_typ_q)) begin
          out_code_d = ERR_TYPE;
        end else if (s1_ofs_q >= s1_cnt_q) begin
          out_code_d = ERR_RANGE;
        end else begin
          out_code_d = ERR_OK;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_vld_q  <= 1'b0;
      out_addr_q <= '0;
      out_cnt_q  <= '0;
      out_code_q <= ERR_OK;
    end else begin
      out_vld_q  <= out_vld_d;
      out_addr_q <= out_addr_d;
      out_cnt_q  <= out_cnt_d;
      out_code_q <= out_code_d;
    end
  end

  assign rd_valid   = out_vld_q;
  assign rd_addr    = out_addr_q;
  assign rd_count   = out_cnt_q;
  assign rd_errcode = out_code_q;
  assign rd_err     = |out_code_q;

endmodule

// File: tb/tb_label_table.sv
module tb_label_table;

  logic        clk;
  logic        reset_n;
  logic [11:0] lbt_lbidw;
  logic [5:0]  lbt_typw;
  logic [15:0] lbt_basew;
  logic [15:0] lbt_countw;
  logic        lbt_we;
  logic        rd_req;
  logic [11:0] rd_lbid;
  logic [5:0]  rd_typ;
  logic [15:0] rd_ofs;
  logic        rd_ready;
  logic        busy;
  logic        rd_valid;
  logic [15:0] rd_addr;
  logic [15:0] rd_count;
  logic        rd_err;
  logic [1:0]  rd_errcode;

  int tests_run;
  int tests_failed;

  label_table dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .lbt_lbidw  (lbt_lbidw),
    .lbt_typw   (lbt_typw),
    .lbt_basew  (lbt_basew),
    .lbt_countw (lbt_countw),
    .lbt_we     (lbt_we),
    .rd_req     (rd_req),
    .rd_lbid    (rd_lbid),
    .rd_typ     (rd_typ),
    .rd_ofs     (rd_ofs),
    .rd_ready   (rd_ready),
    .busy       (busy),
    .rd_valid   (rd_valid),
    .rd_addr    (rd_addr),
    .rd_count   (rd_count),
    .rd_err     (rd_err),
    .rd_errcode (rd_errcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus: one write, held for exactly one edge.
  task automatic do_write(input logic [11:0] id, input logic [5:0] t,
                          input logic [15:0] b, input logic [15:0] c);
    @(posedge clk); #1;
    lbt_we = 1'b1; lbt_lbidw = id; lbt_typw = t; lbt_basew = b; lbt_countw = c;
    @(posedge clk); #1;
    lbt_we = 1'b0;
  endtask

  // Stimulus: one lookup; returns what the DUT shows two edges after acceptance.
  task automatic do_lookup(input logic [11:0] id, input logic [5:0] t,
                           input logic [15:0] o,
                           output logic vld, output logic [15:0] addr,
                           output logic [15:0] cnt, output logic err,
                           output logic [1:0] code);
    @(posedge clk); #1;
    rd_req = 1'b1; rd_lbid = id; rd_typ = t; rd_ofs = o;
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vld = rd_valid; addr = rd_addr; cnt = rd_count; err = rd_err; code = rd_errcode;
  endtask

  task automatic test_reset;
    int  n;
    bit  seen;
    logic vld, err;
    logic [15:0] addr, cnt;
    logic [1:0] code;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b1 || rd_ready !== 1'b0 || rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: busy=%b rd_ready=%b rd_valid=%b, want 1 0 0", busy, rd_ready, rd_valid);
    end
    tests_run++;
    if (rd_addr !== 16'h0 || rd_count !== 16'h0 || rd_err !== 1'b0 || rd_errcode !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_data: addr=%h count=%h err=%b code=%b, want 0 0 0 00",
               rd_addr, rd_count, rd_err, rd_errcode);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    rd_req = 1'b1; rd_lbid = 12'd5; rd_typ = 6'd0; rd_ofs = 16'd0;
    n = 0; seen = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (rd_valid === 1'b1) seen = 1;
      if (busy !== 1'b1) break;
      n++;
    end
    rd_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rd_valid === 1'b1) seen = 1;
    end
    tests_run++;
    if (n != 4096) begin
      tests_failed++;
      $display("FAIL sweep_len: busy cycles=%0d, want 4096", n);
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL sweep_ignore_req: rd_valid seen=%b, want 0", seen);
    end
    tests_run++;
    if (rd_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_state: rd_ready=%b busy=%b, want 1 0", rd_ready, busy);
    end
    do_lookup(12'd5, 6'd0, 16'd0, vld, addr, cnt, err, code);
    tests_run++;
    if (vld !== 1'b1 || code !== 2'b01 || err !== 1'b1 || addr !== 16'h0 || cnt !== 16'h0) begin
      tests_failed++;
      $display("FAIL unset_lookup: vld=%b code=%b err=%b addr=%h cnt=%h, want 1 01 1 0000 0000",
               vld, code, err, addr, cnt);
    end
  endtask

  task automatic test_lookup;
    logic vld, err;
    logic [15:0] addr, cnt;
    logic [1:0] code;
    do_write(12'd3, 6'd2, 16'h1000, 16'd8);
    do_lookup(12'd3, 6'd2, 16'd7, vld, addr, cnt, err, code);
    tests_run++;
    if (vld !== 1'b1 || addr !== 16'h1007 || cnt !== 16'd8 || err !== 1'b0 || code !== 2'b00) begin
      tests_failed++;
      $display("FAIL basic_lookup: vld=%b addr=%h cnt=%0d err=%b code=%b, want 1 1007 8 0 00",
               vld, addr, cnt, err, code);
    end
  endtask

  task automatic test_errors;
    logic vld, err;
    logic [15:0] addr, cnt;
    logic [1:0] code;
    do_lookup(12'd3, 6'd2, 16'd8, vld, addr, cnt, err, code);
    tests_run++;
    if (vld !== 1'b1 || code !== 2'b11 || err !== 1'b1 || addr !== 16'h1008 || cnt !== 16'd8) begin
      tests_failed++;
      $display("FAIL range_err: vld=%b code=%b err=%b addr=%h cnt=%0d, want 1 11 1 1008 8",
               vld, code, err, addr, cnt);
    end
    do_lookup(12'd3, 6'd4, 16'd0, vld, addr, cnt, err, code);
    tests_run++;
    if (vld !== 1'b1 || code !== 2'b10 || err !== 1'b1 || addr !== 16'h1000) begin
      tests_failed++;
      $display("FAIL type_err: vld=%b code=%b err=%b addr=%h, want 1 10 1 1000", vld, code, err, addr);
    end
    do_lookup(12'd3, 6'd0, 16'd0, vld, addr, cnt, err, code);
    tests_run++;
    if (vld !== 1'b1 || code !== 2'b00 || err !== 1'b0 || addr !== 16'h1000) begin
      tests_failed++;
      $display("FAIL any_type: vld=%b code=%b err=%b addr=%h, want 1 00 0 1000", vld, code, err, addr);
    end
    // Type mismatch outranks range: wrong type and out-of-range offset.
    do_lookup(12'd3, 6'd4, 16'd9, vld, addr, cnt, err, code);
    tests_run++;
    if (code !== 2'b10) begin
      tests_failed++;
      $display("FAIL type_over_range: code=%b, want 10", code);
    end
  endtask

  task automatic test_forward;
    logic vld, err;
    logic [15:0] addr, cnt;
    logic [1:0] code;
    // Write and request on the same edge.
    @(posedge clk); #1;
    lbt_we = 1'b1; lbt_lbidw = 12'd9; lbt_typw = 6'd1; lbt_basew = 16'hFFFE; lbt_countw = 16'd4;
    rd_req = 1'b1; rd_lbid = 12'd9; rd_typ = 6'd1; rd_ofs = 16'd3;
    @(posedge clk); #1;
    lbt_we = 1'b0; rd_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (rd_valid !== 1'b1 || rd_errcode !== 2'b00 || rd_addr !== 16'h0001 || rd_count !== 16'd4) begin
      tests_failed++;
      $display("FAIL fwd_wrap: vld=%b code=%b addr=%h cnt=%0d, want 1 00 0001 4",
               rd_valid, rd_errcode, rd_addr, rd_count);
    end
    // Write one edge after the request must not be seen.
    @(posedge clk); #1;
    rd_req = 1'b1; rd_lbid = 12'd10; rd_typ = 6'd1; rd_ofs = 16'd1;
    @(posedge clk); #1;
    rd_req = 1'b0;
    lbt_we = 1'b1; lbt_lbidw = 12'd10; lbt_typw = 6'd1; lbt_basew = 16'h2000; lbt_countw = 16'd2;
    @(posedge clk); #1;
    lbt_we = 1'b0;
    @(negedge clk);
    tests_run++;
    if (rd_valid !== 1'b1 || rd_errcode !== 2'b01 || rd_addr !== 16'h0) begin
      tests_failed++;
      $display("FAIL late_write: vld=%b code=%b addr=%h, want 1 01 0000", rd_valid, rd_errcode, rd_addr);
    end
    do_lookup(12'd10, 6'd1, 16'd1, vld, addr, cnt, err, code);
    tests_run++;
    if (vld !== 1'b1 || code !== 2'b00 || addr !== 16'h2001 || cnt !== 16'd2) begin
      tests_failed++;
      $display("FAIL late_write_landed: vld=%b code=%b addr=%h cnt=%0d, want 1 00 2001 2",
               vld, code, addr, cnt);
    end
  endtask

  task automatic test_back_to_back;
    @(posedge clk); #1;
    rd_req = 1'b1; rd_lbid = 12'd3; rd_typ = 6'd2; rd_ofs = 16'd1;
    @(posedge clk); #1;
    rd_lbid = 12'd3; rd_typ = 6'd2; rd_ofs = 16'd8;
    @(posedge clk); #1;
    rd_lbid = 12'd9; rd_typ = 6'd1; rd_ofs = 16'd0;
    @(negedge clk);
    tests_run++;
    if (rd_valid !== 1'b1 || rd_errcode !== 2'b00 || rd_addr !== 16'h1001) begin
      tests_failed++;
      $display("FAIL b2b_first: vld=%b code=%b addr=%h, want 1 00 1001", rd_valid, rd_errcode, rd_addr);
    end
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if (rd_valid !== 1'b1 || rd_errcode !== 2'b11 || rd_addr !== 16'h1008) begin
      tests_failed++;
      $display("FAIL b2b_second: vld=%b code=%b addr=%h, want 1 11 1008", rd_valid, rd_errcode, rd_addr);
    end
    @(negedge clk);
    tests_run++;
    if (rd_valid !== 1'b1 || rd_errcode !== 2'b00 || rd_addr !== 16'hFFFE || rd_count !== 16'd4) begin
      tests_failed++;
      $display("FAIL b2b_third: vld=%b code=%b addr=%h cnt=%0d, want 1 00 fffe 4",
               rd_valid, rd_errcode, rd_addr, rd_count);
    end
    @(negedge clk);
    tests_run++;
    if (rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_strobe_end: vld=%b, want 0", rd_valid);
    end
  endtask

  task automatic test_reset_midflight;
    bit seen;
    int n;
    logic vld, err;
    logic [15:0] addr, cnt;
    logic [1:0] code;
    seen = 0;
    @(posedge clk); #1;
    rd_req = 1'b1; rd_lbid = 12'd3; rd_typ = 6'd2; rd_ofs = 16'd0;
    @(posedge clk); #1;
    rd_ofs = 16'd1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    rd_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rd_valid === 1'b1) seen = 1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_inflight: rd_valid seen=%b, want 0", seen);
    end
    tests_run++;
    if (busy !== 1'b1 || rd_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busy: busy=%b rd_ready=%b, want 1 0", busy, rd_ready);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      n++;
    end
    tests_run++;
    if (n != 4096) begin
      tests_failed++;
      $display("FAIL resweep_len: busy cycles=%0d, want 4096", n);
    end
    do_lookup(12'd3, 6'd2, 16'd0, vld, addr, cnt, err, code);
    tests_run++;
    if (vld !== 1'b1 || code !== 2'b01 || addr !== 16'h0 || cnt !== 16'h0) begin
      tests_failed++;
      $display("FAIL entry_cleared: vld=%b code=%b addr=%h cnt=%h, want 1 01 0000 0000",
               vld, code, addr, cnt);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n    = 1'b0;
    lbt_we     = 1'b0;
    lbt_lbidw  = '0;
    lbt_typw   = '0;
    lbt_basew  = '0;
    lbt_countw = '0;
    rd_req     = 1'b0;
    rd_lbid    = '0;
    rd_typ     = '0;
    rd_ofs     = '0;
    test_reset;
    test_lookup;
    test_errors;
    test_forward;
    test_back_to_back;
    test_reset_midflight;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
